// File: rtl/cmac_link_ctrl.sv
// cmac_link_ctrl: brings up a CMAC link and keeps it up.
//   Waits for RX alignment after enable, retries with a reset request and a
//   holdoff when alignment does not arrive in time, drops back to waiting
//   (with remote-fault indication) when alignment is lost.
// Optional feature macro: CMAC_LINK_STATS_EN enables the link-up / timeout
//   statistics counters; when undefined the counter ports read 0.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   enable               link enable (clk domain)
//   stat_rx_aligned      CMAC RX alignment (asynchronous)
//   stats_clear          one-cycle pulse, clears statistics
//   ctl_rx_enable        CMAC RX enable
//   ctl_tx_enable        CMAC TX enable
//   ctl_tx_send_rfi      CMAC remote-fault indication
//   link_up              link established
//   reset_req            one-cycle CMAC/datapath reset request
//   state                current state (IDLE=0, WAIT_ALIGN=1, UP=2, HOLDOFF=3)
//   linkup_count         saturating count of link-up events
//   timeout_count        saturating count of alignment timeouts
module cmac_link_ctrl #(
    parameter int unsigned CLK_HZ           = 250000000,
    parameter int unsigned ALIGN_TIMEOUT_MS = 10,
    parameter int unsigned HOLDOFF_USECS    = 100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        stat_rx_aligned,
    input  logic        stats_clear,
    output logic        ctl_rx_enable,
    output logic        ctl_tx_enable,
    output logic        ctl_tx_send_rfi,
    output logic        link_up,
    output logic        reset_req,
    output logic [1:0]  state,
    output logic [15:0] linkup_count,
    output logic [15:0] timeout_count
);

    localparam int unsigned TIMER_W        = 32;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned TIMEOUT_CYCLES = (CLK_HZ / 1000) * ALIGN_TIMEOUT_MS;
    localparam int unsigned HOLDOFF_CYCLES = (CLK_HZ / 1000000) * HOLDOFF_USECS;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_ALIGN = 2'd1,
        ST_UP         = 2'd2,
        ST_HOLDOFF    = 2'd3
    } state_t;

    // Moore output decode, packed as {rx_enable, tx_enable, send_rfi, link_up}
    function automatic logic [3:0] ctl_decode(input state_t s);
        case (s)
            ST_WAIT_ALIGN: ctl_decode = 4'b1010;
            ST_UP:         ctl_decode = 4'b1101;
            default:       ctl_decode = 4'b0000;
        endcase
    endfunction

    logic               r_sync1;
    logic               r_aligned_s;
    state_t             r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_reset_req;
    logic [3:0]         r_ctl;

    // Alignment synchroniser plus link FSM; ctl outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1     <= 1'b0;
            r_aligned_s <= 1'b0;
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_reset_req <= 1'b0;
            r_ctl       <= ctl_decode(ST_IDLE);
        end else begin
            r_sync1     <= stat_rx_aligned;
            r_aligned_s <= r_sync1;
            r_reset_req <= 1'b0;
            if (!enable) begin
                r_state <= ST_IDLE;
                r_ctl   <= ctl_decode(ST_IDLE);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WAIT_ALIGN;
                        r_ctl   <= ctl_decode(ST_WAIT_ALIGN);
                        r_timer <= TIMER_W'(TIMEOUT_CYCLES);
                    end
                    ST_WAIT_ALIGN: begin
                        // alignment wins over a same-cycle timeout
                        if (r_aligned_s) begin
                            r_state <= ST_UP;
                            r_ctl   <= ctl_decode(ST_UP);
                        end else if (r_timer == '0) begin
                            r_state     <= ST_HOLDOFF;
                            r_ctl       <= ctl_decode(ST_HOLDOFF);
                            r_reset_req <= 1'b1;
                            r_timer     <= TIMER_W'(HOLDOFF_CYCLES);
                        end else begin
                            r_timer <= r_timer - TIMER_W'(1);
                        end
                    end
                    ST_UP: begin
                        if (!r_aligned_s) begin
                            r_state <= ST_WAIT_ALIGN;
                            r_ctl   <= ctl_decode(ST_WAIT_ALIGN);
                            r_timer <= TIMER_W'(TIMEOUT_CYCLES);
                        end
                    end
                    ST_HOLDOFF: begin
                        if (r_timer == '0) begin
                            r_state <= ST_WAIT_ALIGN;
                            r_ctl   <= ctl_decode(ST_WAIT_ALIGN);
                            r_timer <= TIMER_W'(TIMEOUT_CYCLES);
                        end else begin
                            r_timer <= r_timer - TIMER_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ctl   <= ctl_decode(ST_IDLE);
                    end
                endcase
            end
        end
    end

    assign ctl_rx_enable   = r_ctl[3];
    assign ctl_tx_enable   = r_ctl[2];
    assign ctl_tx_send_rfi = r_ctl[1];
    assign link_up         = r_ctl[0];
    assign reset_req       = r_reset_req;
    assign state           = r_state;

`ifdef CMAC_LINK_STATS_EN
    logic             w_linkup_evt;
    logic             w_timeout_evt;
    logic [CNT_W-1:0] r_linkup_count;
    logic [CNT_W-1:0] r_timeout_count;

    // Same conditions the FSM uses for WAIT_ALIGN->UP and for a reset request
    assign w_linkup_evt  = enable && (r_state == ST_WAIT_ALIGN) && r_aligned_s;
    assign w_timeout_evt = enable && (r_state == ST_WAIT_ALIGN) && !r_aligned_s
                           && (r_timer == '0);

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!resetn || stats_clear) begin
            r_linkup_count  <= '0;
            r_timeout_count <= '0;
        end else begin
            if (w_linkup_evt && (r_linkup_count != {CNT_W{1'b1}}))
                r_linkup_count <= r_linkup_count + CNT_W'(1);
            if (w_timeout_evt && (r_timeout_count != {CNT_W{1'b1}}))
                r_timeout_count <= r_timeout_count + CNT_W'(1);
        end
    end

    assign linkup_count  = r_linkup_count;
    assign timeout_count = r_timeout_count;
`else
    logic w_unused_stats_clear;

    assign w_unused_stats_clear = stats_clear;
    assign linkup_count         = CNT_W'(0);
    assign timeout_count        = CNT_W'(0);
`endif

endmodule

// File: doc/cmac_link_ctrl.md
CMAC_LINK_CTRL -- requirements
Module: cmac_link_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 250000000, clk frequency in Hz.
REQ-002 SHALL have parameter ALIGN_TIMEOUT_MS, default 10, max time in WAIT_ALIGN before a reset request.
REQ-003 SHALL have parameter HOLDOFF_USECS, default 100, dwell time in HOLDOFF after a reset request.
REQ-004 SHALL have the following ports, one per line:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  link enable from config registers, synchronous to clk.
- stat_rx_aligned  in  1  CMAC RX alignment, asynchronous.
- stats_clear  in  1  one-cycle pulse that clears statistics.
- ctl_rx_enable  out  1  CMAC RX enable.
- ctl_tx_enable  out  1  CMAC TX enable.
- ctl_tx_send_rfi  out  1  CMAC send remote-fault indication.
- link_up  out  1  link established.
- reset_req  out  1  one-cycle pulse requesting a CMAC/datapath reset.
- state  out  2  current state encoding.
- linkup_count  out  16  count of link-up events.
- timeout_count  out  16  count of alignment timeouts.

Function
REQ-005 SHALL synchronise stat_rx_aligned through a 2-flop synchroniser into aligned_s; all decisions SHALL use aligned_s only.
REQ-006 SHALL implement states IDLE=0, WAIT_ALIGN=1, UP=2, HOLDOFF=3, driven on state.
REQ-007 Outputs SHALL be a Moore decode of the state register:
- IDLE: all ctl outputs 0, link_up 0.
- WAIT_ALIGN: ctl_rx_enable=1, ctl_tx_send_rfi=1, ctl_tx_enable=0.
- UP: ctl_rx_enable=1, ctl_tx_enable=1, ctl_tx_send_rfi=0, link_up=1.
- HOLDOFF: all ctl outputs 0, link_up 0.
REQ-008 A 32-bit down-timer SHALL be used. TIMEOUT_CYCLES = (CLK_HZ/1000)*ALIGN_TIMEOUT_MS. HOLDOFF_CYCLES = (CLK_HZ/1000000)*HOLDOFF_USECS.
REQ-009 IDLE -> WAIT_ALIGN when enable=1; the timer SHALL be loaded with TIMEOUT_CYCLES.
REQ-010 In WAIT_ALIGN, the following SHALL apply in priority order:
- aligned_s=1 -> UP.
- else timer==0 -> HOLDOFF, reset_req=1 for that one cycle, timer loaded with HOLDOFF_CYCLES.
- else timer decrements.
REQ-011 Alignment SHALL win over timeout when both occur in the same cycle.
REQ-012 UP -> WAIT_ALIGN when aligned_s=0; the timer SHALL be reloaded with TIMEOUT_CYCLES; reset_req SHALL NOT pulse.
REQ-013 In HOLDOFF, the timer SHALL decrement; at timer==0 -> WAIT_ALIGN with the timer reloaded with TIMEOUT_CYCLES.
REQ-014 enable=0 SHALL force IDLE on the next edge from any state, overriding every other transition and suppressing reset_req.
REQ-015 Latency: stat_rx_aligned high, sampled at edge N while in WAIT_ALIGN, SHALL give link_up=1 after edge N+2 (2 sync flops plus the state register).
REQ-016 reset_req SHALL assert TIMEOUT_CYCLES+1 cycles after entry into WAIT_ALIGN when alignment never arrives.

Reset
REQ-017 While resetn=0 at an edge:
- state=IDLE, timer=0, reset_req=0, synchroniser flops=0, counters=0.
- Consequently all ctl outputs and link_up SHALL be 0.
REQ-018 Reset asserted mid-operation (any state, including during a reset_req cycle) SHALL take effect at the next edge with no residual pulse.

Configuration
REQ-019 Macro CMAC_LINK_STATS_EN SHALL control the statistics counters.
REQ-020 With CMAC_LINK_STATS_EN defined:
- linkup_count SHALL increment on each WAIT_ALIGN->UP transition.
- timeout_count SHALL increment on each reset_req pulse.
- Both counters SHALL saturate at 16'hFFFF.
- stats_clear SHALL zero both counters and win over a same-cycle increment.
REQ-021 With CMAC_LINK_STATS_EN undefined, linkup_count and timeout_count SHALL be tied to 0, stats_clear SHALL be ignored, and the ports SHALL remain present.

Verification (CLK_HZ=1000000, ALIGN_TIMEOUT_MS=1 -> 1000 cycles, HOLDOFF_USECS=10 -> 10 cycles)
REQ-022 Bench SHALL cover the following scenarios:
- Bring-up: enable=1, aligned raised 50 cycles later -> link_up=1 exactly 3 cycles after the raise; tx_enable=1; rfi=0; linkup_count=1.
- Timeout: enable=1, aligned held 0 -> reset_req single pulse 1001 cycles after WAIT_ALIGN entry; HOLDOFF for 11 cycles; back to WAIT_ALIGN; timeout_count=1.
- Link drop: in UP, aligned 1->0 -> state=1 and rfi=1 three cycles later; no reset_req; recovery on re-align.
- Disable priority: enable=0 on the same cycle the timer hits 0 -> state=IDLE, reset_req stays 0.
- Reset mid-HOLDOFF: resetn=0 for 1 cycle -> all outputs 0 and counters 0 next cycle.
- Stats: force 65536 link-up events (or preload) -> linkup_count holds FFFF; stats_clear plus increment in the same cycle -> 0. With the macro undefined -> counters read 0 throughout.
